// File: rtl/int8_mac_pkg.sv
// Shared constants and types for the int8 MAC array front end.
package int8_mac_pkg;

   localparam int LANE_W    = 8;
   localparam int MAC_LANES = 33;
   localparam int VEC_W     = LANE_W * MAC_LANES;
   localparam int PSUM_W    = 24;

   // Packer states: collecting lanes, presenting a vector, presenting a
   // vector that is followed by a spill-only tail vector.
   typedef enum logic [1:0] {
      FILL      = 2'd0,
      HOLD      = 2'd1,
      HOLD_TAIL = 2'd2
   } pack_state_t;

endpackage

// File: rtl/int8_lane_bank.sv
// LANES x 8-bit register bank for operands A and B.
// Writes up to BEAT_LANES lanes starting at wr_ptr. A clear zeroes every lane
// and, in the same cycle, loads ld_cnt spill lanes into lanes 0..ld_cnt-1.
module int8_lane_bank
   import int8_mac_pkg::*;
#(
   parameter int LANES      = MAC_LANES,
   parameter int BEAT_LANES = 4,
   localparam int PTR_W     = $clog2(LANES + 1),
   localparam int NL_W      = $clog2(BEAT_LANES + 1),
   localparam int BW        = LANE_W * BEAT_LANES
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [PTR_W-1:0]          wr_ptr,
   input  logic [NL_W-1:0]           wr_cnt,
   input  logic [BW-1:0]             wr_a,
   input  logic [BW-1:0]             wr_b,
   input  logic                      clr,
   input  logic [NL_W-1:0]           ld_cnt,
   input  logic [BW-1:0]             ld_a,
   input  logic [BW-1:0]             ld_b,
   output logic [LANE_W*LANES-1:0]   a_vec,
   output logic [LANE_W*LANES-1:0]   b_vec
);

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [LANE_W-1:0] a_q, b_q;
      logic [LANE_W-1:0] wa, wb, la, lb;
      logic              wr_hit, ld_hit;
      int                off;

      // Select which beat lane (if any) lands in this bank lane.
      always_comb begin
         off    = j - int'(wr_ptr);
         wr_hit = wr_en && (off >= 0) && (off < int'(wr_cnt));
         wa     = '0;
         wb     = '0;
         for (int i = 0; i < BEAT_LANES; i++) begin
            if (off == i) begin
               wa = wr_a[i*LANE_W +: LANE_W];
               wb = wr_b[i*LANE_W +: LANE_W];
            end
         end
      end

      // Only the low BEAT_LANES lanes can ever receive spilled bytes.
      if (j < BEAT_LANES) begin : g_ld
         assign ld_hit = (j < int'(ld_cnt));
         assign la     = ld_a[j*LANE_W +: LANE_W];
         assign lb     = ld_b[j*LANE_W +: LANE_W];
      end else begin : g_no_ld
         assign ld_hit = 1'b0;
         assign la     = '0;
         assign lb     = '0;
      end

      // Lane register: clear/spill-load has priority over a beat write.
      always_ff @(posedge clk) begin
         // NOTE: the bank is reset explicitly because zero-padding of a short final vector relies on cleared lanes.
         if (rst) begin
            a_q <= '0;
            b_q <= '0;
         end else if (clr) begin
            a_q <= ld_hit ? la : '0;
            b_q <= ld_hit ? lb : '0;
         end else if (wr_hit) begin
            a_q <= wa;
            b_q <= wb;
         end
      end

      assign a_vec[j*LANE_W +: LANE_W] = a_q;
      assign b_vec[j*LANE_W +: LANE_W] = b_q;
   end

endmodule

// File: rtl/int8_vec_packer.sv
// Packs a narrow stream of int8 operand pairs into LANES-wide A/B vectors for
// the MAC array, zero-padding the last vector of a dot product and carrying
// lanes that straddle a vector boundary into the next vector.
// Optional build macro: INT8_PACK_STATS_EN adds stat_vecs / stat_stall counters.
module int8_vec_packer
   import int8_mac_pkg::*;
#(
   parameter int LANES      = MAC_LANES,
   parameter int BEAT_LANES = 4,
   parameter int STAT_W     = 32,
   localparam int NL_W      = $clog2(BEAT_LANES + 1),
   localparam int BW        = LANE_W * BEAT_LANES
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [BW-1:0]             in_a,
   input  logic [BW-1:0]             in_b,
   input  logic                      in_last,
   input  logic [NL_W-1:0]           in_nlanes,
   output logic                      vec_valid,
   input  logic                      vec_ready,
   output logic [LANE_W*LANES-1:0]   a_vec,
   output logic [LANE_W*LANES-1:0]   b_vec,
   output logic                      vec_last
`ifdef INT8_PACK_STATS_EN
  ,output logic [STAT_W-1:0]         stat_vecs,
   output logic [STAT_W-1:0]         stat_stall
`endif
);

   localparam int PTR_W = $clog2(LANES + 1);
   localparam int SUM_W = $clog2(LANES + BEAT_LANES + 1);

   pack_state_t       state_q, state_d;
   logic [PTR_W-1:0]  fill_ptr_q;
   logic [NL_W-1:0]   spill_cnt_q;
   logic [BW-1:0]     spill_a_q, spill_b_q;
   logic              vec_last_q;

   logic              accept, handshake;
   logic [NL_W-1:0]   beat_cnt, spill_n, stored;
   logic [SUM_W-1:0]  sum;
   logic              fills;
   logic [BW-1:0]     spill_a_d, spill_b_d;

   assign accept    = in_valid && in_ready;
   assign handshake = vec_valid && vec_ready;

   // Split the incoming beat into lanes kept in the bank and lanes that spill.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred on any path.
      beat_cnt  = NL_W'(BEAT_LANES);
      spill_a_d = '0;
      spill_b_d = '0;
      if (in_last) begin
         beat_cnt = (int'(in_nlanes) > BEAT_LANES) ? NL_W'(BEAT_LANES) : in_nlanes;
      end
      sum     = SUM_W'(fill_ptr_q) + SUM_W'(beat_cnt);
      fills   = (sum >= SUM_W'(LANES));
      spill_n = fills ? NL_W'(sum - SUM_W'(LANES)) : '0;
      stored  = beat_cnt - spill_n;
      for (int m = 0; m < BEAT_LANES; m++) begin
         for (int i = 0; i < BEAT_LANES; i++) begin
            if ((i == m + int'(stored)) && (m < int'(spill_n))) begin
               spill_a_d[m*LANE_W +: LANE_W] = in_a[i*LANE_W +: LANE_W];
               spill_b_d[m*LANE_W +: LANE_W] = in_b[i*LANE_W +: LANE_W];
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      if (rst) state_q <= FILL;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FILL:      if (accept && (fills || in_last))
                       state_d = (in_last && (spill_n != '0)) ? HOLD_TAIL : HOLD;
         HOLD:      if (handshake) state_d = FILL;
         HOLD_TAIL: if (handshake) state_d = HOLD;
         default:   state_d = FILL;
      endcase
   end

   // Output decode from state.
   always_comb begin
      in_ready  = (state_q == FILL);
      vec_valid = (state_q != FILL);
   end

   // Fill pointer, spill buffer and end-of-dot-product flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_ptr_q  <= '0;
         spill_cnt_q <= '0;
         spill_a_q   <= '0;
         spill_b_q   <= '0;
         vec_last_q  <= 1'b0;
      end else begin
         unique case (state_q)
            FILL: if (accept) begin
               fill_ptr_q <= fill_ptr_q + PTR_W'(stored);
               if (fills || in_last) begin
                  spill_cnt_q <= spill_n;
                  spill_a_q   <= spill_a_d;
                  spill_b_q   <= spill_b_d;
                  vec_last_q  <= in_last && (spill_n == '0);
               end
            end
            HOLD: if (handshake) begin
               fill_ptr_q  <= PTR_W'(spill_cnt_q);
               spill_cnt_q <= '0;
               vec_last_q  <= 1'b0;
            end
            HOLD_TAIL: if (handshake) begin
               fill_ptr_q  <= '0;
               spill_cnt_q <= '0;
               vec_last_q  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   int8_lane_bank #(
      .LANES      (LANES),
      .BEAT_LANES (BEAT_LANES)
   ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (accept),
      .wr_ptr (fill_ptr_q),
      .wr_cnt (stored),
      .wr_a   (in_a),
      .wr_b   (in_b),
      .clr    (handshake),
      .ld_cnt (spill_cnt_q),
      .ld_a   (spill_a_q),
      .ld_b   (spill_b_q),
      .a_vec  (a_vec),
      .b_vec  (b_vec)
   );

   assign vec_last = vec_last_q;

`ifdef INT8_PACK_STATS_EN
   // Handshake and stall counters, wrapping modulo 2^STAT_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_vecs  <= '0;
         stat_stall <= '0;
      end else begin
         if (vec_valid && vec_ready)  stat_vecs  <= stat_vecs + STAT_W'(1);
         if (vec_valid && !vec_ready) stat_stall <= stat_stall + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_int8_vec_packer.sv
// Directed self-checking bench for int8_vec_packer (LANES=33, BEAT_LANES=4).
module tb_int8_vec_packer;

   localparam int LANES = 33;
   localparam int VW    = 8 * LANES;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_last;
   logic [31:0]   in_a, in_b;
   logic [2:0]    in_nlanes;
   logic          vec_valid, vec_ready, vec_last;
   logic [VW-1:0] a_vec, b_vec;
`ifdef INT8_PACK_STATS_EN
   logic [31:0]   stat_vecs, stat_stall;
   logic [31:0]   stall_base;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [VW-1:0] q_a[$];
   logic [VW-1:0] q_b[$];
   logic          q_last[$];

   always #5 clk = ~clk;

   int8_vec_packer #(.LANES(LANES), .BEAT_LANES(4), .STAT_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .in_nlanes (in_nlanes),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready),
      .a_vec     (a_vec),
      .b_vec     (b_vec),
      .vec_last  (vec_last)
`ifdef INT8_PACK_STATS_EN
     ,.stat_vecs (stat_vecs),
      .stat_stall(stat_stall)
`endif
   );

   // Record every vector handshake, sampled mid-cycle.
   always @(negedge clk) begin
      if (vec_valid && vec_ready) begin
         q_a.push_back(a_vec);
         q_b.push_back(b_vec);
         q_last.push_back(vec_last);
      end
   end

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected vector: lanes 0..n-1 hold bytes first..first+n-1 (xor x), rest zero.
   function automatic logic [VW-1:0] vec(input int first, input int n, input logic [7:0] x);
      logic [VW-1:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[i*8 +: 8] = 8'(first + i) ^ x;
      return v;
   endfunction

   task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                            input logic last, input logic [2:0] nl);
      bit ok;
      ok = 1'b0;
      in_a = a; in_b = b; in_last = last; in_nlanes = nl; in_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("beat_accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   // nbeats beats of consecutive bytes from 'first'; last_nl >= 0 marks the final beat in_last.
   task automatic send_run(input int first, input int nbeats, input int last_nl);
      logic [31:0] a, b;
      bit          lst;
      for (int k = 0; k < nbeats; k++) begin
         lst = (last_nl >= 0) && (k == nbeats - 1);
         for (int i = 0; i < 4; i++) begin
            if (lst && i >= last_nl) begin
               a[i*8 +: 8] = 8'hEE;
               b[i*8 +: 8] = 8'hEE;
            end else begin
               a[i*8 +: 8] = 8'(first + 4*k + i);
               b[i*8 +: 8] = 8'(first + 4*k + i) ^ 8'h80;
            end
         end
         send_beat(a, b, lst, lst ? 3'(last_nl) : 3'd0);
      end
   endtask

   task automatic wait_vecs(input int n);
      for (int c = 0; c < 400; c++) begin
         if (q_a.size() >= n) break;
         @(negedge clk);
      end
      repeat (4) @(posedge clk);
      #1;
      check("vec_count", VW'(q_a.size()), VW'(n));
   endtask

   task automatic check_vec(input string tag, input int idx, input int first,
                            input int n, input logic last);
      if (idx < q_a.size()) begin
         check({tag, "_a"},    q_a[idx], vec(first, n, 8'h00));
         check({tag, "_b"},    q_b[idx], vec(first, n, 8'h80));
         check({tag, "_last"}, VW'(q_last[idx]), VW'(last));
      end else begin
         check({tag, "_missing"}, 0, 1);
      end
   endtask

   task automatic flush_q();
      q_a.delete(); q_b.delete(); q_last.delete();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_nlanes = '0;
      in_a = '0; in_b = '0; vec_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      check("rst_vec_valid", VW'(vec_valid), 0);
      check("rst_in_ready",  VW'(in_ready),  1);
      check("rst_a_vec",     a_vec, '0);
      check("rst_b_vec",     b_vec, '0);
      check("rst_vec_last",  VW'(vec_last),  0);

      // 8 full beats + last beat with one lane, stalled 5 cycles downstream.
      vec_ready = 1'b0;
      send_run(1, 8, -1);
      check("t1_no_vec_yet", VW'(vec_valid), 0);
      send_run(33, 1, 1);
      check("t1_latency", VW'(vec_valid), 1);
`ifdef INT8_PACK_STATS_EN
      stall_base = stat_stall;
`endif
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("t1_stall_a",     a_vec, vec(1, 33, 8'h00));
         check("t1_stall_b",     b_vec, vec(1, 33, 8'h80));
         check("t1_stall_last",  VW'(vec_last),  1);
         check("t1_stall_ready", VW'(in_ready),  0);
         check("t1_stall_valid", VW'(vec_valid), 1);
         @(posedge clk); #1;
      end
`ifdef INT8_PACK_STATS_EN
      check("t1_stat_stall", VW'(stat_stall - stall_base), 5);
`endif
      vec_ready = 1'b1;
      wait_vecs(1);
      check_vec("t1_v0", 0, 1, 33, 1'b1);
      flush_q();

      // 9 beats, last carries 4 lanes: boundary straddle into a tail vector.
      send_run(1, 9, 4);
      wait_vecs(2);
      check_vec("t2_v0", 0, 1,  33, 1'b0);
      check_vec("t2_v1", 1, 34, 3,  1'b1);
      flush_q();

      // 33 full beats, no last: 132 bytes across exactly 4 vectors.
      send_run(1, 33, -1);
      wait_vecs(4);
      for (int v = 0; v < 4; v++) check_vec($sformatf("t3_v%0d", v), v, 1 + 33*v, 33, 1'b0);
      flush_q();

      // Empty dot product at lane 0: single all-zero vector with vec_last.
      send_run(0, 1, 0);
      wait_vecs(1);
      check_vec("t4_v0", 0, 0, 0, 1'b1);
      flush_q();

      // Reset after 4 beats discards the partial vector.
      send_run(8'hC0, 4, -1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t5_vec_valid", VW'(vec_valid), 0);
      check("t5_in_ready",  VW'(in_ready),  1);
      check("t5_a_zero",    a_vec, '0);
      send_run(1, 8, -1);
      send_run(33, 1, 1);
      wait_vecs(1);
      check_vec("t5_v0", 0, 1, 33, 1'b1);
      flush_q();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
